// File: rtl/hvac_zone_if.sv
// Zone bus between the sensor sampler / supervisor side (master) and the
// heat/cool controller (slave). Clock and reset are kept as plain ports on
// the modules that use this interface.
interface hvac_zone_if #(
  parameter int TEMP_W = 8,
  parameter int TOL_W  = 4
);
  // Supervisor / sampler side
  logic [1:0]        mode;            // 00 OFF, 01 HEAT_ONLY, 10 COOL_ONLY, 11 AUTO
  logic [TEMP_W-1:0] current_temp;
  logic [TEMP_W-1:0] desired_temp;
  logic [TOL_W-1:0]  temp_tolerance;
  logic              sensor_valid;
  logic              fault_clr;

  // Relay drives and status
  logic              heater_on;
  logic              cooler_on;
  logic              fan_on;
  logic              fault;
  logic [4:0]        state_o;         // one-hot {FAULT,LOCKOUT,COOLING,HEATING,IDLE}

  modport master (
    output mode, current_temp, desired_temp, temp_tolerance, sensor_valid, fault_clr,
    input  heater_on, cooler_on, fan_on, fault, state_o
  );

  modport slave (
    input  mode, current_temp, desired_temp, temp_tolerance, sensor_valid, fault_clr,
    output heater_on, cooler_on, fan_on, fault, state_o
  );
endinterface

// File: rtl/hvac_zone_controller.sv
// Single-zone heat/cool controller: mode select, saturating hysteresis
// thresholds, minimum-on and post-off lockout dwell, sensor-stale watchdog
// and latched fault. Relay drives are decoded straight from the state register.
//
// Build option: define HVAC_FAN_POSTRUN_EN to keep the fan running for
// FAN_POSTRUN_CYC cycles after heating/cooling stops. Without it the fan
// simply follows the heater/cooler drives.
module hvac_zone_controller #(
  parameter int TEMP_W          = 8,
  parameter int TOL_W           = 4,
  parameter int MIN_ON_CYC      = 16,
  parameter int MIN_OFF_CYC     = 8,
  parameter int STALE_CYC       = 4,
  parameter int FAN_POSTRUN_CYC = 10
) (
  input  logic        clk,
  input  logic        reset,
  hvac_zone_if.slave  zone
);

  typedef enum logic [4:0] {
    S_IDLE    = 5'b00001,
    S_HEATING = 5'b00010,
    S_COOLING = 5'b00100,
    S_LOCKOUT = 5'b01000,
    S_FAULT   = 5'b10000
  } state_t;

  // One dwell counter serves both the min-on and the lockout timers, so it is
  // sized for the longer of the two.
  localparam int DWELL_MAX = (MIN_ON_CYC > MIN_OFF_CYC) ? MIN_ON_CYC : MIN_OFF_CYC;
  localparam int DWELL_W   = $clog2(DWELL_MAX + 1);
  localparam int STALE_W   = $clog2(STALE_CYC + 1);

  localparam logic [DWELL_W-1:0] ON_LIM    = DWELL_W'(MIN_ON_CYC);
  localparam logic [DWELL_W-1:0] OFF_LIM   = DWELL_W'(MIN_OFF_CYC);
  localparam logic [STALE_W-1:0] STALE_LIM = STALE_W'(STALE_CYC);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [DWELL_W-1:0] r_dwell;
  logic [DWELL_W-1:0] w_dwell_nxt;
  logic [STALE_W-1:0] r_stale;
  logic [STALE_W-1:0] w_stale_nxt;
  logic               w_stale_trip;

  logic               w_heat_ok;
  logic               w_cool_ok;
  logic               w_active;
  logic [TEMP_W:0]    w_heat_diff;
  logic [TEMP_W:0]    w_cool_sum;
  logic [TEMP_W-1:0]  w_heat_thr;
  logic [TEMP_W-1:0]  w_cool_thr;

  assign w_heat_ok = zone.mode[0];
  assign w_cool_ok = zone.mode[1];

  // Thresholds are formed one bit wider so the carry/borrow shows up in the
  // top bit; that bit selects the clamp instead of letting the value wrap.
  assign w_heat_diff = {1'b0, zone.desired_temp} - (TEMP_W+1)'(zone.temp_tolerance);
  assign w_cool_sum  = {1'b0, zone.desired_temp} + (TEMP_W+1)'(zone.temp_tolerance);
  assign w_heat_thr  = w_heat_diff[TEMP_W] ? '0 : w_heat_diff[TEMP_W-1:0];
  assign w_cool_thr  = w_cool_sum[TEMP_W]  ? '1 : w_cool_sum[TEMP_W-1:0];

  // Stale watchdog: count consecutive invalid samples, saturating at the trip level.
  assign w_stale_nxt  = zone.sensor_valid       ? '0      :
                        (r_stale == STALE_LIM)  ? r_stale :
                                                  r_stale + 1'b1;
  assign w_stale_trip = (w_stale_nxt == STALE_LIM);

  // Next-state selection: stale fault first, then mode override, then temperature.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can leave
    // it unassigned and infer a latch.
    w_state_nxt = r_state;
    if (w_stale_trip) begin
      w_state_nxt = S_FAULT;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (zone.sensor_valid) begin
            if (w_heat_ok && (zone.current_temp < w_heat_thr)) begin
              w_state_nxt = S_HEATING;
            end else if (w_cool_ok && (zone.current_temp > w_cool_thr)) begin
              w_state_nxt = S_COOLING;
            end
          end
        end
        S_HEATING: begin
          // A mode change cuts the run short regardless of the min-on dwell.
          if (!w_heat_ok) begin
            w_state_nxt = S_LOCKOUT;
          end else if (zone.sensor_valid && (r_dwell == ON_LIM) &&
                       (zone.current_temp >= zone.desired_temp)) begin
            w_state_nxt = S_LOCKOUT;
          end
        end
        S_COOLING: begin
          if (!w_cool_ok) begin
            w_state_nxt = S_LOCKOUT;
          end else if (zone.sensor_valid && (r_dwell == ON_LIM) &&
                       (zone.current_temp <= zone.desired_temp)) begin
            w_state_nxt = S_LOCKOUT;
          end
        end
        S_LOCKOUT: begin
          // Actuator rest period: temperature and mode are deliberately ignored.
          if (r_dwell == OFF_LIM) begin
            w_state_nxt = S_IDLE;
          end
        end
        S_FAULT: begin
          if (zone.fault_clr && zone.sensor_valid) begin
            w_state_nxt = S_LOCKOUT;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Dwell counter: loads 1 on entry to a timed state, then counts up and holds at its limit.
  always_comb begin
    w_dwell_nxt = '0;
    if (w_state_nxt != r_state) begin
      if ((w_state_nxt == S_HEATING) || (w_state_nxt == S_COOLING) ||
          (w_state_nxt == S_LOCKOUT)) begin
        w_dwell_nxt = DWELL_W'(1);
      end
    end else begin
      case (r_state)
        S_HEATING, S_COOLING: w_dwell_nxt = (r_dwell == ON_LIM)  ? r_dwell : r_dwell + 1'b1;
        S_LOCKOUT:            w_dwell_nxt = (r_dwell == OFF_LIM) ? r_dwell : r_dwell + 1'b1;
        default:              w_dwell_nxt = '0;
      endcase
    end
  end

  // State, dwell and stale registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      r_state <= S_IDLE;
      r_dwell <= '0;
      r_stale <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_dwell <= w_dwell_nxt;
      r_stale <= w_stale_nxt;
    end
  end

  assign w_active       = (r_state == S_HEATING) || (r_state == S_COOLING);
  assign zone.heater_on = (r_state == S_HEATING);
  assign zone.cooler_on = (r_state == S_COOLING);
  assign zone.fault     = (r_state == S_FAULT);
  assign zone.state_o   = r_state;

`ifdef HVAC_FAN_POSTRUN_EN
  localparam int                POST_W   = $clog2(FAN_POSTRUN_CYC + 1);
  localparam logic [POST_W-1:0] POST_LIM = POST_W'(FAN_POSTRUN_CYC);

  logic [POST_W-1:0] r_post;

  // Fan overrun: held at full count while active, so it starts draining on the
  // first cycle after the active state is left; a fault kills it at once.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_post <= '0;
    end else if (w_state_nxt == S_FAULT) begin
      r_post <= '0;
    end else if (w_active) begin
      r_post <= POST_LIM;
    end else if (r_post != '0) begin
      r_post <= r_post - 1'b1;
    end
  end

  assign zone.fan_on = w_active || (r_post != '0);
`else
  logic w_unused_postrun;
  assign w_unused_postrun = (FAN_POSTRUN_CYC > 0);
  assign zone.fan_on      = w_active;
`endif

endmodule

// File: tb/tb_hvac_zone_controller.sv
// Bench for hvac_zone_controller with MIN_ON=4, MIN_OFF=3, STALE=2, POSTRUN=5.
// A table of per-cycle stimulus rows carries the expected state after each
// edge; expectations are queued on drive and compared after the edge.
module tb_hvac_zone_controller;

  localparam int TEMP_W = 8;
  localparam int TOL_W  = 4;

  localparam logic [4:0] S_IDLE = 5'b00001;
  localparam logic [4:0] S_HEAT = 5'b00010;
  localparam logic [4:0] S_COOL = 5'b00100;
  localparam logic [4:0] S_LOCK = 5'b01000;
  localparam logic [4:0] S_FLT  = 5'b10000;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  hvac_zone_if #(.TEMP_W(TEMP_W), .TOL_W(TOL_W)) zone ();

  hvac_zone_controller #(
    .TEMP_W(TEMP_W), .TOL_W(TOL_W), .MIN_ON_CYC(4), .MIN_OFF_CYC(3),
    .STALE_CYC(2), .FAN_POSTRUN_CYC(5)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .zone  (zone)
  );

  typedef struct {
    logic        rst;
    logic [1:0]  mode;
    logic [7:0]  cur;
    logic [7:0]  des;
    logic [3:0]  tol;
    logic        valid;
    logic        fclr;
    logic [4:0]  exp_state;
    logic        exp_fan_pr;   // fan expectation when the postrun build is used
  } vec_t;

  typedef struct {
    logic [4:0] state;
    logic       fan;
    int         idx;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input int idx, input logic [4:0] act,
                       input logic [4:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s (row %0d): got %b, expected %b", name, idx, act, req);
    end
  endtask

  task automatic add(input logic rst, input logic [1:0] mode, input logic [7:0] cur,
                     input logic [7:0] des, input logic [3:0] tol, input logic valid,
                     input logic fclr, input logic [4:0] st, input logic fan_pr);
    vec_t v;
    v.rst = rst; v.mode = mode; v.cur = cur; v.des = des; v.tol = tol;
    v.valid = valid; v.fclr = fclr; v.exp_state = st; v.exp_fan_pr = fan_pr;
    vecs.push_back(v);
  endtask

  function automatic logic fan_model(input vec_t v);
`ifdef HVAC_FAN_POSTRUN_EN
    return v.exp_fan_pr;
`else
    return (v.exp_state == S_HEAT) || (v.exp_state == S_COOL);
`endif
  endfunction

  task automatic compare_outputs();
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard: output with no queued expectation");
    end else begin
      e = sb.pop_front();
      check("state_o",   e.idx, zone.state_o,   e.state);
      check("heater_on", e.idx, 5'(zone.heater_on), 5'(e.state == S_HEAT));
      check("cooler_on", e.idx, 5'(zone.cooler_on), 5'(e.state == S_COOL));
      check("fault",     e.idx, 5'(zone.fault),     5'(e.state == S_FLT));
      check("fan_on",    e.idx, 5'(zone.fan_on),    5'(e.fan));
    end
  endtask

  task automatic drive(input vec_t v, input int idx);
    exp_t e;
    @(negedge clk);
    reset               = v.rst;
    zone.mode           = v.mode;
    zone.current_temp   = v.cur;
    zone.desired_temp   = v.des;
    zone.temp_tolerance = v.tol;
    zone.sensor_valid   = v.valid;
    zone.fault_clr      = v.fclr;
    e.state = v.exp_state;
    e.fan   = fan_model(v);
    e.idx   = idx;
    sb.push_back(e);
    @(posedge clk);
    #1;
    compare_outputs();
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    zone.mode           = 2'b00;
    zone.current_temp   = 8'd0;
    zone.desired_temp   = 8'd50;
    zone.temp_tolerance = 4'd3;
    zone.sensor_valid   = 1'b1;
    zone.fault_clr      = 1'b0;

    //   rst mode cur  des  tol v  fclr  state   fan_pr
    add(1, 0,   0,   50,  3,  1, 0,    S_IDLE, 0);
    add(1, 0,   0,   50,  3,  1, 0,    S_IDLE, 0);
    // AUTO heat, min-on 4 cycles, lockout 3 cycles, then postrun drains
    add(0, 3,   46,  50,  3,  1, 0,    S_HEAT, 1);
    add(0, 3,   55,  50,  3,  1, 0,    S_HEAT, 1);
    add(0, 3,   55,  50,  3,  1, 0,    S_HEAT, 1);
    add(0, 3,   55,  50,  3,  1, 0,    S_HEAT, 1);
    add(0, 3,   55,  50,  3,  1, 0,    S_LOCK, 1);
    add(0, 3,   55,  50,  3,  1, 0,    S_LOCK, 1);
    add(0, 3,   55,  50,  3,  1, 0,    S_LOCK, 1);
    add(0, 3,   50,  50,  3,  1, 0,    S_IDLE, 1);
    add(0, 3,   50,  50,  3,  1, 0,    S_IDLE, 1);
    add(0, 3,   50,  50,  3,  1, 0,    S_IDLE, 0);
    // threshold clamping and exact-threshold boundaries
    add(0, 3,   0,   2,   5,  1, 0,    S_IDLE, 0);
    add(0, 3,   255, 253, 5,  1, 0,    S_IDLE, 0);
    add(0, 3,   47,  50,  3,  1, 0,    S_IDLE, 0);
    add(0, 3,   53,  50,  3,  1, 0,    S_IDLE, 0);
    // cooling interrupted by mode change at dwell 2, then heating
    add(0, 3,   60,  50,  3,  1, 0,    S_COOL, 1);
    add(0, 3,   60,  50,  3,  1, 0,    S_COOL, 1);
    add(0, 1,   60,  50,  3,  1, 0,    S_LOCK, 1);
    add(0, 1,   10,  50,  3,  1, 0,    S_LOCK, 1);
    add(0, 1,   10,  50,  3,  1, 0,    S_LOCK, 1);
    add(0, 1,   10,  50,  3,  1, 0,    S_IDLE, 1);
    add(0, 1,   10,  50,  3,  1, 0,    S_HEAT, 1);
    // stale sensor -> fault; clear needs valid in the same cycle
    add(0, 1,   10,  50,  3,  0, 0,    S_HEAT, 1);
    add(0, 1,   10,  50,  3,  0, 0,    S_FLT,  0);
    add(0, 1,   10,  50,  3,  0, 1,    S_FLT,  0);
    add(0, 1,   10,  50,  3,  1, 0,    S_FLT,  0);
    add(0, 1,   10,  50,  3,  0, 1,    S_FLT,  0);
    add(0, 1,   10,  50,  3,  1, 1,    S_LOCK, 0);
    add(0, 1,   10,  50,  3,  1, 0,    S_LOCK, 0);
    add(0, 1,   10,  50,  3,  1, 0,    S_LOCK, 0);
    add(0, 1,   10,  50,  3,  1, 0,    S_IDLE, 0);
    add(0, 1,   10,  50,  3,  1, 0,    S_HEAT, 1);
    add(0, 1,   10,  50,  3,  1, 0,    S_HEAT, 1);
    // synchronous reset mid-heating
    add(1, 1,   10,  50,  3,  1, 0,    S_IDLE, 0);
    add(0, 1,   10,  50,  3,  1, 0,    S_HEAT, 1);
    // mode OFF forces lockout, overriding min-on
    add(0, 0,   10,  50,  3,  1, 0,    S_LOCK, 1);
    add(0, 0,   10,  50,  3,  1, 0,    S_LOCK, 1);
    add(0, 0,   10,  50,  3,  1, 0,    S_LOCK, 1);
    add(0, 0,   10,  50,  3,  1, 0,    S_IDLE, 1);
    add(0, 0,   10,  50,  3,  1, 0,    S_IDLE, 1);
    add(0, 0,   10,  50,  3,  1, 0,    S_IDLE, 0);
    // COOL_ONLY full run, fan postrun after leaving COOLING
    add(0, 2,   60,  50,  3,  1, 0,    S_COOL, 1);
    add(0, 2,   45,  50,  3,  1, 0,    S_COOL, 1);
    add(0, 2,   45,  50,  3,  1, 0,    S_COOL, 1);
    add(0, 2,   45,  50,  3,  1, 0,    S_COOL, 1);
    add(0, 2,   45,  50,  3,  1, 0,    S_LOCK, 1);
    add(0, 2,   45,  50,  3,  1, 0,    S_LOCK, 1);
    add(0, 2,   45,  50,  3,  1, 0,    S_LOCK, 1);
    add(0, 2,   45,  50,  3,  1, 0,    S_IDLE, 1);
    add(0, 2,   45,  50,  3,  1, 0,    S_IDLE, 1);
    add(0, 2,   45,  50,  3,  1, 0,    S_IDLE, 0);
    // mode gating in IDLE, invalid sample holds IDLE
    add(0, 0,   10,  50,  3,  1, 0,    S_IDLE, 0);
    add(0, 1,   60,  50,  3,  1, 0,    S_IDLE, 0);
    add(0, 1,   10,  50,  3,  0, 0,    S_IDLE, 0);
    add(0, 1,   10,  50,  3,  1, 0,    S_HEAT, 1);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i], i);
    end

    // Reset must act only at the clock edge: no change while it is merely asserted.
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("sync_reset_pre_edge_state",  -1, zone.state_o, S_HEAT);
    check("sync_reset_pre_edge_heater", -1, 5'(zone.heater_on), 5'd1);
    @(posedge clk);
    #1;
    check("sync_reset_post_edge_state", -1, zone.state_o, S_IDLE);
    check("sync_reset_post_edge_drive", -1,
          5'({zone.heater_on, zone.cooler_on, zone.fan_on, zone.fault}), 5'd0);
    @(negedge clk);
    reset = 1'b0;

    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard: %0d expectations left unconsumed", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
